lsu_mem_port: RTL

- Load/store unit sitting directly downstream of the core control block.
- Takes the effective address, access type and store data that control produces.
- Runs one request/response transaction on the data-memory bus per access.
- Stalls the pipeline while the transaction is in flight, then returns lane-aligned load data to control. Control performs sign/zero extension.

---
 rtl/core_pkg.sv | 20 ++
 rtl/lsu_lane_align.sv | 61 ++++++
 rtl/lsu_mem_port.sv | 131 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: access size encodings, LSU FSM states, datapath width.
package core_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: alignment check, write strobes and write-data
// placement for a new request, and right-justification of a returned read beat.
module lsu_lane_align #(
    parameter  int XLEN  = core_pkg::XLEN,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [1:0]       req_size,
    input  logic [OFF_W-1:0] req_off,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             req_misalign,
    output logic [NB-1:0]    req_wstrb,
    output logic [XLEN-1:0]  req_wdata_lane,
    input  logic [1:0]       rsp_size,
    input  logic [OFF_W-1:0] rsp_off,
    input  logic [XLEN-1:0]  rsp_rdata,
    output logic [XLEN-1:0]  rsp_rdata_aligned
);
    import core_pkg::*;

    logic [NB-1:0]   req_bytes;
    logic [XLEN-1:0] rsp_mask;

    // Request side: size mask and natural-alignment check, then shift into the lane.
    always_comb begin
        req_bytes    = '0;
        req_misalign = 1'b0;
        case (lsu_size_e'(req_size))
            SZ_B: begin
                req_bytes    = NB'(8'h01);
            end
            SZ_H: begin
                req_bytes    = NB'(8'h03);
                req_misalign = req_off[0];
            end
            SZ_W: begin
                req_bytes    = NB'(8'h0F);
                req_misalign = |req_off[1:0];
            end
            default: begin
                req_bytes    = '1;
                req_misalign = |req_off;
            end
        endcase
        req_wstrb      = req_bytes << req_off;
        req_wdata_lane = req_wdata << {req_off, 3'b000};
    end

    // Response side: bring the addressed lane down to bit 0 and clear bytes beyond the size.
    always_comb begin
        rsp_mask = '1;
        case (lsu_size_e'(rsp_size))
            SZ_B:    rsp_mask = XLEN'(8'hFF);
            SZ_H:    rsp_mask = XLEN'(16'hFFFF);
            SZ_W:    rsp_mask = XLEN'(32'hFFFF_FFFF);
            default: rsp_mask = '1;
        endcase
        rsp_rdata_aligned = (rsp_rdata >> {rsp_off, 3'b000}) & rsp_mask;
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit: turns one control-block access into one request/response
// transaction on the data-memory bus, stalling the pipeline while it is in flight.
module lsu_mem_port #(
    parameter  int XLEN   = core_pkg::XLEN,
    parameter  int ADDR_W = 64,
    localparam int NB     = XLEN / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ls_rd_en,
    input  logic              ls_wr_en,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [XLEN-1:0]   ls_wdata,
    output logic [XLEN-1:0]   ls_rdata,
    output logic              ls_done,
    output logic              ls_stall,
    output logic              ls_misalign,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [NB-1:0]     bus_req_wstrb,
    output logic [XLEN-1:0]   bus_req_wdata,
    input  logic              bus_rsp_valid,
    input  logic [XLEN-1:0]   bus_rsp_rdata
);
    import core_pkg::*;

    lsu_state_e       state_q, state_d;
    logic [1:0]       size_q;
    logic [OFF_W-1:0] off_q;

    logic             ls_req;
    logic             req_illegal;
    logic             req_misalign;
    logic             req_ok;
    logic             req_bad;
    logic             start;
    logic             capture;
    logic [NB-1:0]    lane_wstrb;
    logic [XLEN-1:0]  lane_wdata;
    logic [XLEN-1:0]  lane_rdata;

    lsu_lane_align #(.XLEN(XLEN)) u_lane (
        .req_size          (ls_size),
        .req_off           (ls_addr[OFF_W-1:0]),
        .req_wdata         (ls_wdata),
        .req_misalign      (req_misalign),
        .req_wstrb         (lane_wstrb),
        .req_wdata_lane    (lane_wdata),
        .rsp_size          (size_q),
        .rsp_off           (off_q),
        .rsp_rdata         (bus_rsp_rdata),
        .rsp_rdata_aligned (lane_rdata)
    );

    assign ls_req      = ls_rd_en | ls_wr_en;
    assign req_illegal = ls_rd_en & ls_wr_en;
    assign req_ok      = ls_req & ~req_illegal & ~req_misalign;
    assign req_bad     = ls_req & (req_illegal | req_misalign);

    // Only an IDLE cycle may launch a request; a request seen in DONE waits one bubble.
    assign start   = (state_q == LSU_IDLE) && req_ok;
    // Stores get a response too, but only loads update the returned data.
    assign capture = (state_q == LSU_WAIT) && bus_rsp_valid && !bus_req_we;

    assign bus_req_valid = (state_q == LSU_REQ);
    assign ls_done       = (state_q == LSU_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LSU_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and pipeline hold; stall drops in DONE so control advances with ls_done.
    always_comb begin
        state_d  = state_q;
        ls_stall = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                ls_stall = req_ok;
                if (req_ok) state_d = LSU_REQ;
            end
            LSU_REQ: begin
                ls_stall = 1'b1;
                if (bus_req_ready) state_d = LSU_WAIT;
            end
            LSU_WAIT: begin
                ls_stall = 1'b1;
                if (bus_rsp_valid) state_d = LSU_DONE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // Request fields are latched once at launch so they stay stable while REQ waits for ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_we    <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wstrb <= '0;
            bus_req_wdata <= '0;
            size_q        <= '0;
            off_q         <= '0;
        end else if (start) begin
            bus_req_we    <= ls_wr_en;
            bus_req_addr  <= {ls_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_req_wstrb <= lane_wstrb;
            bus_req_wdata <= lane_wdata;
            size_q        <= ls_size;
            off_q         <= ls_addr[OFF_W-1:0];
        end
    end

    // Load data holds until the next load completes; misalign is a one-cycle flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ls_rdata    <= '0;
            ls_misalign <= 1'b0;
        end else begin
            ls_misalign <= (state_q == LSU_IDLE) && req_bad;
            if (capture) ls_rdata <= lane_rdata;
        end
    end

endmodule
